// File: rtl/enigma_plugboard_prog.sv
// ---------------------------------------------------------------------------
// enigma_plugboard_prog
//
// Programmable Enigma plugboard (Steckerbrett). Holds a reciprocal swap
// table covering the whole alphabet. Plug pairs can be installed at runtime
// through a validated pair-write port. A clear sweep restores the identity
// mapping one entry per cycle. Two independent registered lookup channels
// serve the keyboard/lamp side (forward) and the entry-wheel return path
// (reverse).
//
// Parameters
//   ALPHA      alphabet size (2..64)
//   MAX_PAIRS  maximum simultaneous plug pairs (1..ALPHA/2)
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   cfg_clear       pulse, starts or restarts the identity-restoring sweep
//   cfg_pair_valid  pair write request for letters cfg_a / cfg_b
//   cfg_ready       pair write is accepted this cycle when requested
//   cfg_done        one-cycle pulse after an accepted pair write
//   cfg_err         qualifies cfg_done: 1 = pair rejected, table unchanged
//   pair_count      number of installed pairs
//   busy            clear sweep in progress
//   fw_*            forward lookup channel (valid/char in, valid/char out)
//   rev_*           reverse lookup channel (valid/char in, valid/char out)
// ---------------------------------------------------------------------------
module enigma_plugboard_prog #(
    parameter  int ALPHA     = 26,
    parameter  int MAX_PAIRS = 13,
    localparam int W         = $clog2(ALPHA),
    localparam int CW        = $clog2(MAX_PAIRS + 1)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cfg_clear,
    input  logic          cfg_pair_valid,
    input  logic [W-1:0]  cfg_a,
    input  logic [W-1:0]  cfg_b,
    output logic          cfg_ready,
    output logic          cfg_done,
    output logic          cfg_err,
    output logic [CW-1:0] pair_count,
    output logic          busy,

    input  logic          fw_valid_in,
    input  logic [W-1:0]  fw_char_in,
    output logic          fw_valid_out,
    output logic [W-1:0]  fw_char_out,

    input  logic          rev_valid_in,
    input  logic [W-1:0]  rev_char_in,
    output logic          rev_valid_out,
    output logic [W-1:0]  rev_char_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [W-1:0]   idx;
    logic [W-1:0]   next_idx;

    // Swap table; always an involution, map[map[x]] == x.
    logic [W-1:0]   map [ALPHA];

    logic           sweep_we;
    logic           enter_clear;

    logic           a_ok;
    logic           b_ok;
    logic [W-1:0]   map_a;
    logic [W-1:0]   map_b;
    logic           pair_accept;
    logic           pair_err;
    logic           pair_install;

    logic           fw_accept;
    logic           rev_accept;
    logic [W-1:0]   fw_result;
    logic [W-1:0]   rev_result;

    // The code width can hold values beyond the alphabet when ALPHA is not
    // a power of two; such codes never index the table.
    function automatic logic in_range(input logic [W-1:0] c);
        return (32'(c) < ALPHA);
    endfunction

    // FSM state and sweep index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // Next-state logic. A clear request during the sweep restarts it from
    // entry 0; the sweep leaves CLEAR right after writing the last entry.
    always_comb begin
        next_state  = state;
        next_idx    = idx;
        sweep_we    = 1'b0;
        enter_clear = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_clear) begin
                    next_state  = CLEAR;
                    next_idx    = '0;
                    enter_clear = 1'b1;
                end
            end
            CLEAR: begin
                sweep_we = 1'b1;
                if (cfg_clear) begin
                    next_idx    = '0;
                    enter_clear = 1'b1;
                end else if (idx == W'(ALPHA - 1)) begin
                    next_state = IDLE;
                    next_idx   = '0;
                end else begin
                    next_idx = idx + W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_idx   = '0;
            end
        endcase
    end

    assign busy      = (state == CLEAR);
    assign cfg_ready = (state == IDLE) && !cfg_clear;

    // Pair validation. Out-of-range letters are muxed away from the table
    // read so the comparison never depends on a nonexistent entry.
    assign a_ok  = in_range(cfg_a);
    assign b_ok  = in_range(cfg_b);
    assign map_a = a_ok ? map[cfg_a] : cfg_a;
    assign map_b = b_ok ? map[cfg_b] : cfg_b;

    assign pair_accept  = cfg_pair_valid && cfg_ready;
    assign pair_err     = !a_ok || !b_ok
                        || (cfg_a == cfg_b)
                        || (map_a != cfg_a)
                        || (map_b != cfg_b)
                        || (pair_count == CW'(MAX_PAIRS));
    assign pair_install = pair_accept && !pair_err;

    // Swap table. Reset loads identity directly so no sweep is needed after
    // reset. Sweep and install never coincide because installs need IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ALPHA; i++) begin
                map[i] <= W'(i);
            end
        end else if (sweep_we) begin
            map[idx] <= idx;
        end else if (pair_install) begin
            map[cfg_a] <= cfg_b;
            map[cfg_b] <= cfg_a;
        end
    end

    // Installed pair counter, zeroed whenever a sweep (re)starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_count <= '0;
        end else if (enter_clear) begin
            pair_count <= '0;
        end else if (pair_install) begin
            pair_count <= pair_count + CW'(1);
        end
    end

    // Pair write status, reported the cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= pair_accept;
            cfg_err  <= pair_accept && pair_err;
        end
    end

    // Lookup datapath. Reads use the table as it stands before this edge,
    // so a lookup alongside an install sees the old mapping. Codes outside
    // the alphabet pass through unchanged.
    assign fw_accept  = fw_valid_in  && (state == IDLE);
    assign rev_accept = rev_valid_in && (state == IDLE);
    assign fw_result  = in_range(fw_char_in)  ? map[fw_char_in]  : fw_char_in;
    assign rev_result = in_range(rev_char_in) ? map[rev_char_in] : rev_char_in;

    // Forward channel output register; the character holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fw_valid_out <= 1'b0;
            fw_char_out  <= '0;
        end else begin
            fw_valid_out <= fw_accept;
            if (fw_accept) begin
                fw_char_out <= fw_result;
            end
        end
    end

    // Reverse channel output register, identical to the forward channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rev_valid_out <= 1'b0;
            rev_char_out  <= '0;
        end else begin
            rev_valid_out <= rev_accept;
            if (rev_accept) begin
                rev_char_out <= rev_result;
            end
        end
    end

endmodule

// File: tb/tb_enigma_plugboard_prog.sv
// ---------------------------------------------------------------------------
// tb_enigma_plugboard_prog
//
// Self-checking bench for enigma_plugboard_prog with default parameters.
// A behavioural model keeps the plugboard as a plain integer array plus a
// pair count, applying the pair rules directly; directed scenarios are
// followed by a randomized mix of pair writes, lookups and clears.
// ---------------------------------------------------------------------------
module tb_enigma_plugboard_prog;

    localparam int ALPHA = 26;
    localparam int MAXP  = 13;
    localparam int W     = 5;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_clear;
    logic          cfg_pair_valid;
    logic [W-1:0]  cfg_a;
    logic [W-1:0]  cfg_b;
    logic          cfg_ready;
    logic          cfg_done;
    logic          cfg_err;
    logic [CW-1:0] pair_count;
    logic          busy;
    logic          fw_valid_in;
    logic [W-1:0]  fw_char_in;
    logic          fw_valid_out;
    logic [W-1:0]  fw_char_out;
    logic          rev_valid_in;
    logic [W-1:0]  rev_char_in;
    logic          rev_valid_out;
    logic [W-1:0]  rev_char_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int mm [ALPHA];
    int mcount;
    int last_fw;
    int last_rev;

    always #5 clk = ~clk;

    enigma_plugboard_prog #(
        .ALPHA     (ALPHA),
        .MAX_PAIRS (MAXP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_clear      (cfg_clear),
        .cfg_pair_valid (cfg_pair_valid),
        .cfg_a          (cfg_a),
        .cfg_b          (cfg_b),
        .cfg_ready      (cfg_ready),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err),
        .pair_count     (pair_count),
        .busy           (busy),
        .fw_valid_in    (fw_valid_in),
        .fw_char_in     (fw_char_in),
        .fw_valid_out   (fw_valid_out),
        .fw_char_out    (fw_char_out),
        .rev_valid_in   (rev_valid_in),
        .rev_char_in    (rev_char_in),
        .rev_valid_out  (rev_valid_out),
        .rev_char_out   (rev_char_out)
    );

    // Single comparison point; counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs at a falling edge, waits for the next
    // falling edge, then returns all requests to idle.
    task automatic applyStimulus(input bit clr, input bit pv, input int a, input int b,
                                 input bit fv, input int fc, input bit rv, input int rc);
        cfg_clear      = clr;
        cfg_pair_valid = pv;
        cfg_a          = W'(a);
        cfg_b          = W'(b);
        fw_valid_in    = fv;
        fw_char_in     = W'(fc);
        rev_valid_in   = rv;
        rev_char_in    = W'(rc);
        @(negedge clk);
        cfg_clear      = 1'b0;
        cfg_pair_valid = 1'b0;
        fw_valid_in    = 1'b0;
        rev_valid_in   = 1'b0;
    endtask

    function automatic int mlook(input int c);
        if (c < ALPHA) return mm[c];
        return c;
    endfunction

    function automatic bit model_err(input int a, input int b);
        if (a >= ALPHA || b >= ALPHA) return 1'b1;
        if (a == b) return 1'b1;
        if (mm[a] != a || mm[b] != b) return 1'b1;
        if (mcount == MAXP) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_identity();
        for (int i = 0; i < ALPHA; i++) mm[i] = i;
        mcount = 0;
    endtask

    task automatic doLookup(input int fc, input int rc);
        int ef;
        int er;
        ef = mlook(fc);
        er = mlook(rc);
        checkOutput("ready_idle", cfg_ready, 1);
        applyStimulus(0, 0, 0, 0, 1, fc, 1, rc);
        checkOutput("fw_valid", fw_valid_out, 1);
        checkOutput($sformatf("fw_char(%0d)", fc), fw_char_out, ef);
        checkOutput("rev_valid", rev_valid_out, 1);
        checkOutput($sformatf("rev_char(%0d)", rc), rev_char_out, er);
        checkOutput("done_pulse", cfg_done, 0);
        last_fw  = ef;
        last_rev = er;
    endtask

    task automatic doPair(input int a, input int b, input bit fv, input int fc,
                          input bit rv, input int rc);
        bit e;
        int ef;
        int er;
        e  = model_err(a, b);
        ef = mlook(fc);
        er = mlook(rc);
        applyStimulus(0, 1, a, b, fv, fc, rv, rc);
        checkOutput($sformatf("done(%0d,%0d)", a, b), cfg_done, 1);
        checkOutput($sformatf("err(%0d,%0d)", a, b), cfg_err, e);
        if (!e) begin
            mm[a] = b;
            mm[b] = a;
            mcount++;
        end
        checkOutput("pair_count", pair_count, mcount);
        checkOutput("pw_fw_valid", fw_valid_out, fv);
        if (fv) last_fw = ef;
        checkOutput("pw_fw_char", fw_char_out, last_fw);
        checkOutput("pw_rev_valid", rev_valid_out, rv);
        if (rv) last_rev = er;
        checkOutput("pw_rev_char", rev_char_out, last_rev);
    endtask

    // Starts a sweep (optionally with a colliding pair write) and follows it
    // cycle by cycle, issuing lookups that must all be dropped.
    task automatic doClear(input bit with_pair, input int a, input int b);
        applyStimulus(1, with_pair, a, b, 0, 0, 0, 0);
        checkOutput("clr_no_done", cfg_done, 0);
        checkOutput("clr_count", pair_count, 0);
        model_identity();
        for (int i = 0; i < ALPHA; i++) begin
            checkOutput($sformatf("busy[%0d]", i), busy, 1);
            checkOutput("clr_ready", cfg_ready, 0);
            applyStimulus(0, 0, 0, 0, 1, $urandom_range(0, 31), 1, $urandom_range(0, 31));
            checkOutput("clr_fw_drop", fw_valid_out, 0);
            checkOutput("clr_rev_drop", rev_valid_out, 0);
            checkOutput("clr_fw_hold", fw_char_out, last_fw);
            checkOutput("clr_rev_hold", rev_char_out, last_rev);
            checkOutput("clr_done_low", cfg_done, 0);
        end
        checkOutput("busy_end", busy, 0);
        checkOutput("ready_end", cfg_ready, 1);
    endtask

    initial begin
        int op;
        rst            = 1'b1;
        cfg_clear      = 1'b0;
        cfg_pair_valid = 1'b0;
        cfg_a          = '0;
        cfg_b          = '0;
        fw_valid_in    = 1'b0;
        fw_char_in     = '0;
        rev_valid_in   = 1'b0;
        rev_char_in    = '0;
        repeat (2) @(negedge clk);

        // Reset values.
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", cfg_done, 0);
        checkOutput("rst_err", cfg_err, 0);
        checkOutput("rst_count", pair_count, 0);
        checkOutput("rst_fw_valid", fw_valid_out, 0);
        checkOutput("rst_fw_char", fw_char_out, 0);
        checkOutput("rst_rev_valid", rev_valid_out, 0);
        checkOutput("rst_rev_char", rev_char_out, 0);
        rst = 1'b0;
        model_identity();
        last_fw  = 0;
        last_rev = 0;

        // Identity mapping after reset, plus pass-through of out-of-range codes.
        for (int i = 0; i < ALPHA; i++) doLookup(i, ALPHA - 1 - i);
        doLookup(27, 31);
        checkOutput("count_after_rst", pair_count, 0);

        // Basic pairs; the second write also checks pre-install reads.
        doPair(0, 9, 1, 0, 1, 9);
        doPair(4, 17, 1, 4, 1, 17);
        doLookup(0, 9);
        doLookup(17, 5);
        doLookup(5, 4);
        checkOutput("count_two", pair_count, 2);

        // Rejected pairs leave the table and the count untouched.
        doPair(3, 3, 0, 0, 0, 0);
        doPair(0, 5, 0, 0, 0, 0);
        doPair(27, 2, 0, 0, 0, 0);
        doPair(2, 26, 0, 0, 0, 0);
        doLookup(3, 5);
        doLookup(2, 0);

        // Fill to the pair limit, then one more.
        doClear(0, 0, 0);
        for (int k = 0; k < MAXP; k++) doPair(2 * k, 2 * k + 1, 1, 2 * k, 0, 0);
        checkOutput("count_full", pair_count, MAXP);
        doPair(5, 20, 0, 0, 0, 0);
        checkOutput("count_still_full", pair_count, MAXP);
        doLookup(25, 12);

        // Clear colliding with a pair write; identity afterwards.
        doClear(1, 3, 7);
        for (int i = 0; i < ALPHA; i++) doLookup(i, i);
        checkOutput("count_after_clr", pair_count, 0);

        // Reset in the middle of a sweep with pairs installed.
        doPair(0, 9, 0, 0, 0, 0);
        doPair(4, 17, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sweep_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_count", pair_count, 0);
        checkOutput("midrst_fw_valid", fw_valid_out, 0);
        checkOutput("midrst_fw_char", fw_char_out, 0);
        checkOutput("midrst_done", cfg_done, 0);
        @(negedge clk);
        rst = 1'b0;
        model_identity();
        last_fw  = 0;
        last_rev = 0;
        doLookup(0, 9);
        for (int i = 0; i < ALPHA; i++) doLookup(i, ALPHA - 1 - i);

        // Randomized mix against the model.
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 99);
            if (op < 3) begin
                doClear($urandom_range(0, 1), $urandom_range(0, 27), $urandom_range(0, 27));
            end else if (op < 50) begin
                doPair($urandom_range(0, 27), $urandom_range(0, 27),
                       $urandom_range(0, 1), $urandom_range(0, 31),
                       $urandom_range(0, 1), $urandom_range(0, 31));
            end else begin
                doLookup($urandom_range(0, 31), $urandom_range(0, 31));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enigma_plugboard_prog.md
# enigma_plugboard_prog

Programmable, parametrised Enigma plugboard (Steckerbrett) with a runtime pair-configuration port and an internal swap table. It replaces the fixed-width, ten-entry static lookup with a reciprocal table covering the whole alphabet, validated pair insertion, a sequential clear sweep, and registered forward/reverse lookups with valid qualifiers. It sits between keyboard/lamp I/O and the rotor stack: the forward channel feeds the entry wheel, and the reverse channel takes the entry-wheel return path.

## Interface
- ALPHA, default 26, alphabet size; legal values 2..64.
- MAX_PAIRS, default 13, maximum simultaneous plug pairs; legal values 1..ALPHA/2.
- W, localparam = $clog2(ALPHA), character code width.
- CW, localparam = $clog2(MAX_PAIRS+1), pair counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_clear  in  1  pulse; starts a sweep that restores the identity mapping.
- cfg_pair_valid  in  1  pair write request.
- cfg_a  in  W  first letter of the pair.
- cfg_b  in  W  second letter of the pair.
- cfg_ready  out  1  pair write accepted this cycle if cfg_pair_valid is also high.
- cfg_done  out  1  one-cycle pulse, the cycle after an accepted pair write.
- cfg_err  out  1  valid with cfg_done; 1 = pair rejected, table unchanged.
- pair_count  out  CW  number of installed pairs.
- busy  out  1  clear sweep in progress.
- fw_valid_in  in  1  forward lookup request.
- fw_char_in  in  W  forward input letter.
- fw_valid_out  out  1  forward result valid.
- fw_char_out  out  W  forward result.
- rev_valid_in  in  1  reverse lookup request.
- rev_char_in  in  W  reverse input letter.
- rev_valid_out  out  1  reverse result valid.
- rev_char_out  out  W  reverse result.

## Operation
- Table map[0..ALPHA-1] of W bits. The mapping is always an involution: map[map[x]] == x.
- FSM states:
  - IDLE: lookups and pair writes allowed.
  - CLEAR: index idx sweeps 0..ALPHA-1, writing map[idx]=idx, one entry per cycle.
- Transitions:
  - IDLE -> CLEAR on cfg_clear.
  - CLEAR -> IDLE after the cycle that writes idx = ALPHA-1. The sweep lasts exactly ALPHA cycles.
  - cfg_clear seen during CLEAR restarts the sweep at idx 0.
  - pair_count is zeroed on entry to CLEAR.
- cfg_ready = (state==IDLE) && !cfg_clear. Clear has priority over a same-cycle pair write; that pair write is not accepted and produces no cfg_done.
- An accepted pair (a,b) is rejected (cfg_err=1) if any of the following hold:
  - a >= ALPHA or b >= ALPHA;
  - a == b;
  - map[a] != a or map[b] != b (a letter is already plugged);
  - pair_count == MAX_PAIRS.
- Otherwise the pair is installed in one cycle: map[a]=b, map[b]=a, pair_count+1.
- Lookups:
  - A lookup is accepted when valid_in is high and state==IDLE.
  - Result = map[char_in] if char_in < ALPHA, otherwise char_in passed through unchanged.
  - Requests arriving during CLEAR are dropped, and valid_out stays 0 for them.
  - Forward and reverse channels are independent and identical. Both may fire in the same cycle.
- A lookup in the same cycle as a pair install reads the pre-install table.

## Timing
- Lookup latency is 1 cycle: registered char_out and valid_out. Throughput is 1 per cycle per channel. No backpressure.
- char_out holds its last value when valid_out = 0.
- Pair write: accepted at edge N; cfg_done/cfg_err at N+1; the table update is visible to lookups accepted from N+1.
- Clear: cfg_clear at edge N; busy=1 from N+1 through N+ALPHA; IDLE and cfg_ready=1 at N+ALPHA+1.
- Reset (asynchronous, any state, including mid-sweep):
  - map = identity;
  - state = IDLE;
  - pair_count = 0;
  - busy, cfg_done, cfg_err, fw_valid_out, rev_valid_out, fw_char_out, rev_char_out = 0;
  - cfg_ready = 1 while rst is low and cfg_clear is low.
- No sweep is needed after reset.

## Test plan
- Reset, then fw lookups 0..25 -> outputs equal inputs, one cycle later; pair_count=0.
- Write pairs (0,9), (4,17) -> two cfg_done pulses, cfg_err=0; fw 0->9, rev 9->0, fw 17->4, fw 5->5; pair_count=2.
- Error cases:
  - write (3,3) -> cfg_err=1;
  - write (0,5) after (0,9) -> cfg_err=1;
  - write (27,2) -> cfg_err=1;
  - in each case the table and pair_count are unchanged.
- Install 13 disjoint pairs, then write a 14th -> cfg_err=1, pair_count=13.
- cfg_clear with a simultaneous pair write -> no cfg_done; busy for exactly 26 cycles; lookups issued during busy return no valid_out; afterwards identity mapping and pair_count=0.
- Assert rst at sweep cycle 10 with pairs installed -> immediately identity mapping, IDLE, busy=0; a lookup on the next cycle returns its input.
